// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem request/ack handshake and
// presents fetched words to decode over valid/ready, absorbing redirects.
module fetch_unit #(
  parameter int            n        = 32,
  parameter logic [n-1:0]  RESET_PC = 'h0040_0000
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [n-1:0] pc,
  input  logic [n-1:0] pc_plus4,
  input  logic         redirect,
  input  logic [n-1:0] redirect_target,
  output logic         imem_req,
  output logic [n-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [n-1:0] imem_rdata,
  output logic         if_valid,
  input  logic         if_ready,
  output logic [n-1:0] if_instr,
  output logic [n-1:0] if_pc,
  output logic [n-1:0] if_pc_plus4
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DROP = 2'd3;

  logic [1:0]   state;
  logic [n-1:0] pend_pc;
  logic [n-1:0] tgt;

  assign tgt       = {redirect_target[n-1:2], 2'b00};
  // Request is decoded from the state flop only, and pc is frozen while it is
  // high, so the address seen by memory is stable until ack.
  assign imem_req  = (state == REQ) || (state == DROP);
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_pc     <= '0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= REQ;
          if (redirect) pc <= tgt;
        end
        REQ: begin
          if (redirect) begin
            // Without ack the request must complete first; park the target.
            if (imem_ack) pc <= tgt;
            else begin
              pend_pc <= tgt;
              state   <= DROP;
            end
          end else if (imem_ack) begin
            if_instr    <= imem_rdata;
            if_pc       <= pc;
            if_pc_plus4 <= pc_plus4;
            if_valid    <= 1'b1;
            pc          <= pc_plus4;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (redirect) begin
            pc       <= tgt;
            if_valid <= 1'b0;
            state    <= REQ;
          end else if (if_ready) begin
            if_valid <= 1'b0;
            state    <= REQ;
          end
        end
        DROP: begin
          if (imem_ack) begin
            pc    <= redirect ? tgt : pend_pc;
            state <= REQ;
          end else if (redirect) begin
            pend_pc <= tgt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then random traffic,
// checked against a transaction-level model of the fetched PC stream.
module tb_fetch_unit;

  localparam logic [31:0] RST = 32'h0040_0000;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc, pc_plus4, redirect_target, imem_addr, imem_rdata;
  logic [31:0] if_instr, if_pc, if_pc_plus4;
  logic        redirect = 1'b0, imem_req, imem_ack = 1'b0, if_valid, if_ready = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: address of the next instruction decode should receive,
  // plus one-cycle-ahead predictions of the handshake outputs.
  logic [31:0] exp_pc;
  logic        discard;
  logic [31:0] pend_tgt;
  logic        ck_hold, ck_vld, vld_exp, ck_req, ck_req_addr, ck_slot;
  logic [31:0] hold_addr, req_addr, slot_pc, slot_instr;

  always #5 clk = ~clk;
  assign pc_plus4 = pc + 32'd4;

  fetch_unit #(.n(32), .RESET_PC(RST)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_plus4(pc_plus4),
    .redirect(redirect), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic clr_model();
    exp_pc = RST; discard = 1'b0; pend_tgt = '0;
    ck_hold = 0; ck_vld = 0; vld_exp = 0; ck_req = 0; ck_req_addr = 0; ck_slot = 0;
    hold_addr = '0; req_addr = '0; slot_pc = '0; slot_instr = '0;
  endtask

  // One clock cycle, entered and left at a negedge.
  task automatic cyc(input bit rd, input logic [31:0] tg, input bit ack, input bit rdy);
    logic [31:0] t;
    t = {tg[31:2], 2'b00};
    chk("addr_is_pc", imem_addr, pc);
    chk("req_vld_excl", {31'b0, imem_req & if_valid}, 32'd0);
    if (ck_hold) begin
      chk("hold_req", {31'b0, imem_req}, 32'd1);
      chk("hold_addr", imem_addr, hold_addr);
    end
    if (ck_vld) chk("vld_next", {31'b0, if_valid}, {31'b0, vld_exp});
    if (ck_req) chk("req_next", {31'b0, imem_req}, 32'd1);
    if (ck_req_addr) chk("req_addr", imem_addr, req_addr);
    if (ck_slot) begin
      chk("slot_pc", if_pc, slot_pc);
      chk("slot_instr", if_instr, slot_instr);
    end
    redirect = rd; redirect_target = tg; imem_ack = ack; if_ready = rdy;
    imem_rdata = (ack && imem_req) ? (imem_addr ^ KEY) : $urandom;
    if (if_valid && rdy) begin
      chk("xfer_pc", if_pc, exp_pc);
      chk("xfer_instr", if_instr, exp_pc ^ KEY);
      chk("xfer_pc4", if_pc_plus4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) exp_pc = t;
    ck_hold = imem_req && !ack; hold_addr = imem_addr;
    ck_vld = 0; ck_req = 0; ck_req_addr = 0;
    ck_slot = if_valid && !rdy && !rd; slot_pc = if_pc; slot_instr = if_instr;
    if (rd) begin ck_vld = 1; vld_exp = 0; end
    else if (imem_req && ack) begin ck_vld = 1; vld_exp = !discard; end
    else if (if_valid && !rdy) begin ck_vld = 1; vld_exp = 1; end
    if (rd && !(imem_req && !ack)) begin ck_req = 1; ck_req_addr = 1; req_addr = t; end
    else if (!rd && imem_req && ack && discard) begin ck_req = 1; ck_req_addr = 1; req_addr = pend_tgt; end
    else if (!rd && if_valid && rdy) begin ck_req = 1; ck_req_addr = 1; req_addr = exp_pc; end
    if (imem_req && ack) discard = 1'b0;
    if (rd && imem_req && !ack) begin discard = 1'b1; pend_tgt = t; end
    @(negedge clk);
  endtask

  // Asynchronous reset mid-cycle, check values immediately, release, reach REQ.
  task automatic do_reset();
    redirect = 0; imem_ack = 0; if_ready = 0; redirect_target = '0; imem_rdata = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_pc", pc, RST);
    chk("rst_addr", imem_addr, RST);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_vld", {31'b0, if_valid}, 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_ifpc", if_pc, 32'd0);
    chk("rst_ifpc4", if_pc_plus4, 32'd0);
    clr_model();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    cyc(0, 0, 0, 0);
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, RST);
  endtask

  initial begin
    clr_model();
    redirect_target = '0; imem_rdata = '0;
    @(negedge clk);
    do_reset();

    // Streaming, zero-wait memory
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1);
      chk("stream_vld", {31'b0, if_valid}, 32'd1);
      chk("stream_pc", if_pc, RST + 32'(4 * i));
      chk("stream_instr", if_instr, (RST + 32'(4 * i)) ^ KEY);
      cyc(0, 0, 0, 1);
    end

    // Backpressure
    cyc(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0);
      chk("bp_vld", {31'b0, if_valid}, 32'd1);
      chk("bp_req", {31'b0, imem_req}, 32'd0);
      chk("bp_pc", if_pc, RST + 32'hC);
    end
    cyc(0, 0, 0, 1);
    chk("bp_release_req", {31'b0, imem_req}, 32'd1);

    // Redirect while request outstanding
    cyc(1, 32'h0040_0103, 0, 0);
    chk("drop_addr0", imem_addr, RST + 32'h10);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("drop_addr2", imem_addr, RST + 32'h10);
    cyc(0, 0, 1, 0);
    chk("drop_vld", {31'b0, if_valid}, 32'd0);
    chk("drop_next", imem_addr, 32'h0040_0100);

    // Redirect in WAIT, then a second redirect overriding a parked one
    cyc(0, 0, 1, 0);
    cyc(1, 32'h0040_0200, 0, 0);
    chk("wait_rd_vld", {31'b0, if_valid}, 32'd0);
    chk("wait_rd_addr", imem_addr, 32'h0040_0200);
    cyc(1, 32'h0040_0280, 0, 0);
    cyc(1, 32'h0040_0300, 0, 0);
    cyc(0, 0, 1, 0);
    chk("latest_wins", imem_addr, 32'h0040_0300);

    // Wrap-around via the external adder
    cyc(1, 32'hFFFF_FFFC, 1, 0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 1, 0);
    chk("wrap_ifpc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pc_plus4, 32'd0);
    cyc(0, 0, 0, 1);
    chk("wrap_next", imem_addr, 32'd0);

    // Reset while in DROP
    cyc(1, 32'h0040_0400, 0, 0);
    do_reset();

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tg;
      tg = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 + ($urandom % 16)) : $urandom;
      cyc(($urandom % 10) == 0, tg, ($urandom % 2) == 0, ($urandom % 3) != 0);
      if (i == 1500) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the CPU. Holds the program counter, drives it to instruction memory and to the PC+4 `adder`, and takes that adder's sum back as the sequential next PC. The fetched word is handed to decode over a valid/ready handshake. Branch/jump redirects from later stages are absorbed without breaking an in-flight memory handshake.

## Interface
Parameters:
- `n`, default `WORDSIZE` (32): address and instruction width.
- `RESET_PC`, default 32'h0040_0000: PC loaded on reset. Its low 2 bits must be 0.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc` out n: current fetch PC. Drives `adder.a`; `adder.b` is tied to 4.
- `pc_plus4` in n: `adder.out`. Must equal `pc + 4` mod 2^n.
- `redirect` in 1: one-cycle pulse requesting a control-flow change.
- `redirect_target` in n: new PC, sampled when `redirect` is 1.
- `imem_req` out 1: instruction memory request.
- `imem_addr` out n: request address.
- `imem_ack` in 1: memory response strobe.
- `imem_rdata` in n: instruction word, valid when `imem_ack` is 1.
- `if_valid` out 1: fetched instruction is available to decode.
- `if_ready` in 1: decode accepts the instruction.
- `if_instr` out n: instruction word.
- `if_pc` out n: address the instruction was fetched from.
- `if_pc_plus4` out n: that address + 4.

## Operation
- Four states:
  - IDLE: held during reset; always lasts one cycle after reset release.
  - REQ: request outstanding.
  - WAIT: output slot full.
  - DROP: request outstanding, response to be discarded.
- `imem_req` = (state == REQ || state == DROP). It is decoded from the state flop only.
- `imem_addr` = `pc`. `pc` never changes while `imem_req` is 1, so the address is stable until ack.
- Memory handshake:
  - Once asserted, `imem_req` stays high until the cycle `imem_ack` is 1.
  - An `imem_ack` while `imem_req` is 0 is ignored.
- Transitions and actions:
  - IDLE -> REQ unconditionally.
  - REQ, `imem_ack`, no `redirect`:
    - Load `if_instr` <= `imem_rdata`, `if_pc` <= `pc`, `if_pc_plus4` <= `pc_plus4`.
    - Set `if_valid` <= 1, `pc` <= `pc_plus4`; go to WAIT.
  - REQ, no `imem_ack`: stay in REQ.
  - WAIT, `if_ready`: clear `if_valid` <= 0; go to REQ.
  - WAIT, no `if_ready`: hold all outputs stable.
- Redirect (highest priority). In every case `redirect_target[1:0]` is forced to 0.
  - In IDLE or WAIT: `pc` <= target, `if_valid` <= 0, go to REQ. A same-cycle `if_valid && if_ready` still counts as transferred; decode discards it.
  - In REQ with `imem_ack` the same cycle: discard `imem_rdata`, `pc` <= target, stay in REQ.
  - In REQ without `imem_ack`: latch target into `pend_pc`, go to DROP.
  - In DROP: overwrite `pend_pc` (latest redirect wins).
- DROP:
  - On `imem_ack`: discard the data, `pc` <= `pend_pc`, go to REQ.
  - If `redirect` and `imem_ack` arrive together, the new target is used directly.
  - `if_valid` stays 0 throughout DROP.
- Arithmetic:
  - The next PC comes only from `pc_plus4`; no internal adder.
  - Wrap-around follows the adder: `pc` = 32'hFFFF_FFFC gives next PC 0. No trap is raised.

## Timing
- Reset values:
  - state = IDLE, `pc` = `RESET_PC`, `pend_pc` = 0.
  - `imem_req` = 0, `imem_addr` = `RESET_PC`.
  - `if_valid` = 0, `if_instr` = 0, `if_pc` = 0, `if_pc_plus4` = 0.
- Reset is effective immediately on `rst_n` falling. Asserting it mid-REQ or mid-DROP abandons the memory handshake; memory must tolerate this.
- All outputs are registered or decoded from the state flop. No combinational path runs from any input to any output.
- Latency:
  - `imem_ack` in cycle t gives `if_valid` = 1 in t+1.
  - `if_ready` in cycle t gives `imem_req` = 1 in t+1.
  - Peak throughput with zero-wait memory is one instruction per 2 cycles.
- Redirect to first request with the new address: 1 cycle from IDLE/REQ+ack/WAIT. From DROP it is 1 cycle after the pending ack.

## Test plan
- Reset: `rst_n`=0 with `RESET_PC`=0x0040_0000, then release. Expect:
  - `pc`=0x0040_0000, `imem_req`=0, `if_valid`=0 during reset.
  - `imem_req`=1 with `imem_addr`=0x0040_0000 on the second cycle after release.
- Streaming: ack the same cycle as each request, `if_ready`=1, `imem_rdata`=address^0xA5A5_A5A5.
  - Expect `if_pc` = 0x0040_0000, 0x0040_0004, 0x0040_0008, two cycles apart.
  - Each `if_instr` matches its address and `if_pc_plus4` = `if_pc`+4.
- Backpressure: hold `if_ready`=0 for 5 cycles in WAIT.
  - Expect `if_valid`=1 and `if_instr`/`if_pc` stable, `imem_req`=0.
  - After `if_ready`=1, `imem_req`=1 the next cycle.
- Redirect mid-request: ack delayed 3 cycles, redirect to 0x0040_0103 in the first REQ cycle.
  - Expect `imem_addr` to hold the old PC until ack and the data to be dropped (`if_valid` stays 0).
  - The next request is at 0x0040_0100.
- Redirect in WAIT to 0x0040_0200 with `if_ready`=0.
  - Expect `if_valid`=0 next cycle, then a request at 0x0040_0200.
  - A second redirect during DROP to 0x0040_0300 must win over the first.
- Wrap and reset: redirect to 0xFFFF_FFFC, then fetch.
  - Expect `if_pc_plus4`=0 and next `imem_addr`=0.
  - Then pulse `rst_n` low during DROP: expect all reset values immediately and `pc` = `RESET_PC`.
